booth_mult_arb: RTL

- Shares one pipelined 15x5 signed Booth multiplier (2-cycle issue-to-result latency, no stall) between NUM_REQ requesters.
- Accepts requests with a round-robin valid/ready handshake and issues at most one operation per cycle.
- Tags each operation through the multiplier pipeline and steers the 20-bit result into a per-requester response register with its own valid/ready handshake.
- Sits between the execute-stage clients and the multiplier instance.

---
 rtl/booth_mult_arb.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/booth_mult_arb.sv
// Round-robin front end sharing one pipelined 15x5 Booth multiplier between NUM_REQ clients.
// Tags ride alongside the multiplier pipeline and steer each product to its requester's response slot.

module booth_mult_arb_lane (
   input  logic        clk,
   input  logic        rst,
   input  logic        issue,
   input  logic        cap,
   input  logic [19:0] res,
   input  logic        resp_ready,
   output logic        pending,
   output logic        resp_valid,
   output logic [19:0] resp_data
);
   logic consume;
   assign consume = resp_valid & resp_ready;

   // issue needs ~pending and capture needs an in-flight tag, so neither can coincide with consume
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending    <= 1'b0;
         resp_valid <= 1'b0;
         resp_data  <= '0;
      end else begin
         if (issue)        pending <= 1'b1;
         else if (consume) pending <= 1'b0;
         if (cap) begin
            resp_valid <= 1'b1;
            resp_data  <= res;
         end else if (consume) begin
            resp_valid <= 1'b0;
         end
      end
   end
endmodule

module booth_mult_arb #(
   parameter int NUM_REQ  = 4,
   parameter int IDW      = 2,
   parameter int MULT_LAT = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_REQ-1:0]      req_valid,
   output logic [NUM_REQ-1:0]      req_ready,
   input  logic [15*NUM_REQ-1:0]   req_mcand,
   input  logic [5*NUM_REQ-1:0]    req_mplier,
   output logic [NUM_REQ-1:0]      resp_valid,
   input  logic [NUM_REQ-1:0]      resp_ready,
   output logic [20*NUM_REQ-1:0]   resp_data,
   output logic                    mult_en,
   output logic [14:0]             mult_mcand,
   output logic [4:0]              mult_mplier,
   input  logic                    mult_out_valid,
   input  logic [19:0]             mult_out,
   output logic                    busy,
   output logic [15:0]             issue_cnt,
   output logic                    proto_err
);
   logic [NUM_REQ-1:0]           pending, elig, gnt, cap;
   logic [NUM_REQ-1:0][14:0]     mcand_a;
   logic [NUM_REQ-1:0][4:0]      mplier_a;
   logic [IDW-1:0]               rr_ptr, gid, ix;
   logic                         gany;
   int                           idx;
   logic [MULT_LAT-1:0]          tv;
   logic [MULT_LAT-1:0][IDW-1:0] tid;
   logic                         last_tv;
   logic [IDW-1:0]               last_tid;

   assign elig     = req_valid & ~pending;
   assign busy     = |pending;
   assign last_tv  = tv[MULT_LAT-1];
   assign last_tid = tid[MULT_LAT-1];

   // first eligible index at or after rr_ptr, wrapping
   always_comb begin
      gnt  = '0;
      gany = 1'b0;
      gid  = '0;
      idx  = 0;
      ix   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         ix = idx[IDW-1:0];
         if (!gany && elig[ix]) begin
            gany = 1'b1;
            gid  = ix;
         end
      end
      if (gany) gnt[gid] = 1'b1;
   end

   assign req_ready = gnt;

   always_comb begin
      mult_en     = gany;
      mult_mcand  = '0;
      mult_mplier = '0;
      if (gany) begin
         mult_mcand  = mcand_a[gid];
         mult_mplier = mplier_a[gid];
      end
   end

   always_comb begin
      cap = '0;
      if (mult_out_valid && last_tv) cap[last_tid] = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr    <= '0;
         tv        <= '0;
         tid       <= '0;
         issue_cnt <= '0;
         proto_err <= 1'b0;
      end else begin
         tv[0]  <= gany;
         tid[0] <= gid;
         for (int s = 1; s < MULT_LAT; s++) begin
            tv[s]  <= tv[s-1];
            tid[s] <= tid[s-1];
         end
         if (gany) begin
            rr_ptr    <= (gid == IDW'(NUM_REQ - 1)) ? '0 : gid + 1'b1;
            issue_cnt <= issue_cnt + 16'd1;
         end
         // result without a tag, or a tag whose result never showed up
         if (mult_out_valid != last_tv) proto_err <= 1'b1;
      end
   end

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
      logic [19:0] data;
      assign mcand_a[i]  = req_mcand[15*i +: 15];
      assign mplier_a[i] = req_mplier[5*i +: 5];
      assign resp_data[20*i +: 20] = data;
      booth_mult_arb_lane u_lane (
         .clk        (clk),
         .rst        (rst),
         .issue      (gnt[i]),
         .cap        (cap[i]),
         .res        (mult_out),
         .resp_ready (resp_ready[i]),
         .pending    (pending[i]),
         .resp_valid (resp_valid[i]),
         .resp_data  (data)
      );
   end
endmodule
